// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between video_timing_gen and its consumers.
// Macro: TEST_PATTERN_EN adds the pat_r/pat_g/pat_b colour-bar signals.
// Signals:
//   x_coord/y_coord    active pixel address (0 outside active)
//   coord_valid        x/y address a visible pixel
//   line_start, fsync  coord-stage pulses at x=0 and at (0,0)
//   hsync, vsync       syncs at their configured polarity
//   hblank, vblank     per-axis blanking
//   active             active video, aligned with the syncs
//   pat_r/g/b          colour-bar test pattern (TEST_PATTERN_EN only)
interface video_timing_gen_if #(
   parameter int unsigned XW = 11,
   parameter int unsigned YW = 10
);
   logic [XW-1:0] x_coord;
   logic [YW-1:0] y_coord;
   logic          coord_valid;
   logic          line_start;
   logic          fsync;
   logic          hsync;
   logic          vsync;
   logic          hblank;
   logic          vblank;
   logic          active;
`ifdef TEST_PATTERN_EN
   logic [7:0]    pat_r;
   logic [7:0]    pat_g;
   logic [7:0]    pat_b;
`endif

   modport master (
      output x_coord, y_coord, coord_valid, line_start, fsync,
             hsync, vsync, hblank, vblank, active
`ifdef TEST_PATTERN_EN
      , output pat_r, pat_g, pat_b
`endif
   );

   modport slave (
      input  x_coord, y_coord, coord_valid, line_start, fsync,
             hsync, vsync, hblank, vblank, active
`ifdef TEST_PATTERN_EN
      , input pat_r, pat_g, pat_b
`endif
   );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator for the HDMI/TMDS pipeline.
// Pixel coordinates lead the sync/blank/active outputs by PIPE_DLY cycles so
// the compositor/ROM read latency is hidden.
// Macro: TEST_PATTERN_EN adds an 8-bar colour pattern aligned with active.
// Ports:
//   pixel_clk  pixel clock
//   rst        async reset, active-high
//   en         clock enable; low freezes counters and pipeline
//   tim        video_timing_gen_if.master: coords, pulses, syncs, blanking
module video_timing_gen #(
   parameter int unsigned H_ACTIVE  = 1280,
   parameter int unsigned H_FP      = 110,
   parameter int unsigned H_SYNC    = 40,
   parameter int unsigned H_BP      = 220,
   parameter int unsigned V_ACTIVE  = 720,
   parameter int unsigned V_FP      = 5,
   parameter int unsigned V_SYNC    = 5,
   parameter int unsigned V_BP      = 20,
   parameter bit          HSYNC_POL = 1'b1,
   parameter bit          VSYNC_POL = 1'b1,
   parameter int unsigned PIPE_DLY  = 2
) (
   input  logic               pixel_clk,
   input  logic               rst,
   input  logic               en,
   video_timing_gen_if.master tim
);
   localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW           = $clog2(H_TOTAL);
   localparam int unsigned VW           = $clog2(V_TOTAL);
   localparam int unsigned XW           = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int unsigned YW           = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam int          PD           = int'(PIPE_DLY);

   // Stage vector: {[pat_r, pat_g, pat_b,] hsync, vsync, hblank, vblank, active}
`ifdef TEST_PATTERN_EN
   localparam int unsigned BAR_W  = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   localparam int unsigned SW     = 29;
   localparam logic [SW-1:0] ST_RST = {24'h000000, ~HSYNC_POL, ~VSYNC_POL, 3'b110};
`else
   localparam int unsigned SW     = 5;
   localparam logic [SW-1:0] ST_RST = {~HSYNC_POL, ~VSYNC_POL, 3'b110};
`endif

   // Reject degenerate timings and out-of-range pipeline depth
   generate
      if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
          V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
          PIPE_DLY > 15) begin : g_param_err
         $error("video_timing_gen: illegal timing parameters");
      end
   endgenerate

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;

   logic          h_vis_c;
   logic          v_vis_c;
   logic          vis_c;
   logic          hs_on_c;
   logic          vs_on_c;
   logic [SW-1:0] st_c;
`ifdef TEST_PATTERN_EN
   logic [31:0]   bar_i_c;
   logic [2:0]    bar_c;
`endif

   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic          valid_q;
   logic          line_start_q;
   logic          fsync_q;
   logic [SW-1:0] st_q;
   logic [SW-1:0] st_out;

   // Raster counters; v advances on h wrap
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (en) begin
         if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            if (v_cnt == VW'(V_TOTAL - 1)) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + VW'(1);
            end
         end else begin
            h_cnt <= h_cnt + HW'(1);
         end
      end
   end

   // Region decode of the current counter position
   always_comb begin
      h_vis_c = (h_cnt < HW'(H_ACTIVE));
      v_vis_c = (v_cnt < VW'(V_ACTIVE));
      vis_c   = h_vis_c & v_vis_c;
      hs_on_c = (h_cnt >= HW'(H_SYNC_START)) && (h_cnt < HW'(H_SYNC_END));
      // v_cnt only moves on h wrap, so vsync changes at h_cnt=0
      vs_on_c = (v_cnt >= VW'(V_SYNC_START)) && (v_cnt < VW'(V_SYNC_END));
      st_c    = ST_RST;
      st_c[4] = hs_on_c ? HSYNC_POL : ~HSYNC_POL;
      st_c[3] = vs_on_c ? VSYNC_POL : ~VSYNC_POL;
      st_c[2] = ~h_vis_c;
      st_c[1] = ~v_vis_c;
      st_c[0] = vis_c;
`ifdef TEST_PATTERN_EN
      bar_i_c = 32'(h_cnt) / BAR_W;
      bar_c   = (bar_i_c > 32'd7) ? 3'd7 : 3'(bar_i_c);
      // Bar index bits map directly onto the classic white..black ordering
      if (vis_c) begin
         st_c[28:21] = bar_c[1] ? 8'h00 : 8'hFF;
         st_c[20:13] = bar_c[2] ? 8'h00 : 8'hFF;
         st_c[12:5]  = bar_c[0] ? 8'h00 : 8'hFF;
      end
`endif
   end

   // Coordinate stage: one cycle after the counters
   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         x_q          <= '0;
         y_q          <= '0;
         valid_q      <= 1'b0;
         line_start_q <= 1'b0;
         fsync_q      <= 1'b0;
         st_q         <= ST_RST;
      end else if (en) begin
         x_q          <= vis_c ? XW'(h_cnt) : '0;
         y_q          <= vis_c ? YW'(v_cnt) : '0;
         valid_q      <= vis_c;
         line_start_q <= vis_c && (h_cnt == '0);
         fsync_q      <= vis_c && (h_cnt == '0) && (v_cnt == '0);
         st_q         <= st_c;
      end
   end

   // Sync-stage delay line
   generate
      if (PD == 0) begin : g_no_dly
         assign st_out = st_q;
      end else begin : g_dly
         logic [SW-1:0] pipe_q [PD];

         always_ff @(posedge pixel_clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < PD; i++) begin
                  pipe_q[i] <= ST_RST;
               end
            end else if (en) begin
               pipe_q[0] <= st_q;
               for (int i = 1; i < PD; i++) begin
                  pipe_q[i] <= pipe_q[i-1];
               end
            end
         end

         assign st_out = pipe_q[PD-1];
      end
   endgenerate

   assign tim.x_coord     = x_q;
   assign tim.y_coord     = y_q;
   assign tim.coord_valid = valid_q;
   assign tim.line_start  = line_start_q;
   assign tim.fsync       = fsync_q;
   assign tim.hsync       = st_out[4];
   assign tim.vsync       = st_out[3];
   assign tim.hblank      = st_out[2];
   assign tim.vblank      = st_out[1];
   assign tim.active      = st_out[0];
`ifdef TEST_PATTERN_EN
   assign tim.pat_r       = st_out[28:21];
   assign tim.pat_g       = st_out[20:13];
   assign tim.pat_b       = st_out[12:5];
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen in a small mode (16x8 raster).
// The reference model derives every output from the number of enabled clock
// edges since reset, using raster arithmetic on the timing parameters.
module tb_video_timing_gen;
   localparam int H_ACTIVE  = 8;
   localparam int H_FP      = 2;
   localparam int H_SYNC    = 3;
   localparam int H_BP      = 3;
   localparam int V_ACTIVE  = 4;
   localparam int V_FP      = 1;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 1;
   localparam int PIPE_DLY  = 2;
   localparam bit HSYNC_POL = 1'b1;
   localparam bit VSYNC_POL = 1'b0;
   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W     = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

   localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   typedef struct {
      int x, y;
      bit valid, ls, fs;
      bit hs, vs, hb, vb, act;
      logic [23:0] rgb;
   } exp_t;

   logic pixel_clk = 1'b0;
   logic rst;
   logic en;
   int   n_cmp = 0;
   int   n_err = 0;
   int   k;

   video_timing_gen_if #(.XW(3), .YW(2)) tim ();

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL), .PIPE_DLY(PIPE_DLY)
   ) dut (
      .pixel_clk(pixel_clk),
      .rst      (rst),
      .en       (en),
      .tim      (tim)
   );

   always #5 pixel_clk = ~pixel_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Expected outputs for raster position pos (pos < 0 means still in reset state)
   function automatic exp_t ref_at(input int pos);
      exp_t e;
      int   h, v, bar;
      e.x = 0; e.y = 0; e.valid = 0; e.ls = 0; e.fs = 0;
      e.hs = !HSYNC_POL; e.vs = !VSYNC_POL; e.hb = 1; e.vb = 1; e.act = 0;
      e.rgb = 24'h0;
      if (pos >= 0) begin
         h = pos % H_TOTAL;
         v = (pos / H_TOTAL) % V_TOTAL;
         e.hb  = !(h < H_ACTIVE);
         e.vb  = !(v < V_ACTIVE);
         e.act = !e.hb && !e.vb;
         e.valid = e.act;
         if (e.act) begin
            e.x = h;
            e.y = v;
            bar = h / BAR_W;
            if (bar > 7) bar = 7;
            e.rgb = BARS[bar];
         end
         e.ls = e.act && (h == 0);
         e.fs = e.act && (h == 0) && (v == 0);
         e.hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HSYNC_POL : !HSYNC_POL;
         e.vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VSYNC_POL : !VSYNC_POL;
      end
      return e;
   endfunction

   // Coord stage shows the position of edge k-1; sync stage lags by PIPE_DLY
   task automatic check_all();
      exp_t c, s;
      c = ref_at(k - 1);
      s = ref_at(k - 1 - PIPE_DLY);
      chk("x_coord",     32'(tim.x_coord),   32'(c.x));
      chk("y_coord",     32'(tim.y_coord),   32'(c.y));
      chk("coord_valid", 32'(tim.coord_valid), 32'(c.valid));
      chk("line_start",  32'(tim.line_start),  32'(c.ls));
      chk("fsync",       32'(tim.fsync),       32'(c.fs));
      chk("hsync",       32'(tim.hsync),       32'(s.hs));
      chk("vsync",       32'(tim.vsync),       32'(s.vs));
      chk("hblank",      32'(tim.hblank),      32'(s.hb));
      chk("vblank",      32'(tim.vblank),      32'(s.vb));
      chk("active",      32'(tim.active),      32'(s.act));
`ifdef TEST_PATTERN_EN
      chk("pat_r", 32'(tim.pat_r), 32'(s.rgb[23:16]));
      chk("pat_g", 32'(tim.pat_g), 32'(s.rgb[15:8]));
      chk("pat_b", 32'(tim.pat_b), 32'(s.rgb[7:0]));
`endif
   endtask

   // One clock: drive en, count the edge in the model, check at the falling edge
   task automatic step(input bit en_v);
      en = en_v;
      @(posedge pixel_clk);
      if (!rst && en) k++;
      @(negedge pixel_clk);
      check_all();
   endtask

   // Mid-cycle async reset; outputs must return to reset values before any edge
   task automatic async_reset();
      #2 rst = 1'b1;
      #1 k = 0;
      check_all();
      #1 rst = 1'b0;
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      en  = 1'b0;
      k   = 0;
      repeat (3) @(negedge pixel_clk);
      check_all();
      rst = 1'b0;

      // Two full frames of free-running scan from reset release
      for (int i = 0; i < 2 * H_TOTAL * V_TOTAL + 20; i++) step(1'b1);

      // Park mid-line in an active row, then hold en low for 5 cycles
      guard = 0;
      while ((((k - 1) % H_TOTAL) != 3 || (((k - 1) / H_TOTAL) % V_TOTAL) >= V_ACTIVE)
             && guard < 200) begin
         step(1'b1);
         guard++;
      end
      chk("park_midline", 32'(guard < 200), 32'd1);
      for (int i = 0; i < 5; i++) step(1'b0);
      for (int i = 0; i < 40; i++) step(1'b1);

      // Reset while coordinates read (5,2), then rescan from (0,0)
      guard = 0;
      while (((k - 1) % (H_TOTAL * V_TOTAL)) != 2 * H_TOTAL + 5 && guard < 200) begin
         step(1'b1);
         guard++;
      end
      chk("park_x5y2", 32'(guard < 200), 32'd1);
      chk("at_x5", 32'(tim.x_coord), 32'd5);
      chk("at_y2", 32'(tim.y_coord), 32'd2);
      async_reset();
      for (int i = 0; i < 3 * H_TOTAL; i++) step(1'b1);

      // Random enable pattern with occasional resets
      for (int i = 0; i < 2500; i++) begin
         step($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) async_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
